// File: rtl/video_src_switch_pkg.sv
// Shared definitions for the video source switch: FSM state encoding,
// sync-polarity helpers and the per-source slice macro for packed streams.
`ifndef VIDEO_SRC_SWITCH_PKG_SV
`define VIDEO_SRC_SWITCH_PKG_SV

`define VID_SLICE(idx, w) ((idx)*(w)) +: (w)

package vid_switch_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_MUTE    = 2'd2
  } sw_state_t;

  localparam int MUTE_CNT_W = 4;

  // Inactive level of a sync signal whose active level is pol.
  function automatic logic sync_idle(input logic pol);
    return ~pol;
  endfunction

endpackage

`endif

// File: rtl/video_src_switch_vs_edge_det.sv
// Multi-lane sync leading-edge detector: flags lanes that are active now
// but were inactive on the previous clock.
module vs_edge_det
  import vid_switch_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter bit VS_POL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] vs,
  output logic [WIDTH-1:0] lead
);

  localparam logic [WIDTH-1:0] POLV = {WIDTH{VS_POL}};

  logic [WIDTH-1:0] vs_p0;

  // Stage p0: previous-cycle sync levels, cleared to the inactive level
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_p0 <= {WIDTH{sync_idle(VS_POL)}};
    end else begin
      vs_p0 <= vs;
    end
  end

  assign lead = ~(vs ^ POLV) & (vs_p0 ^ POLV);

endmodule

// File: rtl/video_src_switch.sv
// N-input video stream selector; source changes take effect only on a VS
// leading edge of the target, optionally followed by muted frames.
module video_src_switch
  import vid_switch_pkg::*;
#(
  parameter int                NUM_SRC      = 4,
  parameter int                DATA_W       = 24,
  parameter int                SEL_W        = 4,
  parameter int                DEFAULT_SEL  = 0,
  parameter bit                HS_POL       = 1'b1,
  parameter bit                VS_POL       = 1'b1,
  parameter int                MUTE_FRAMES  = 1,
  parameter logic [DATA_W-1:0] MUTE_COLOR   = '0,
  parameter int                WAIT_TIMEOUT = 2000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        in_hs,
  input  logic [NUM_SRC-1:0]        in_vs,
  input  logic [NUM_SRC-1:0]        in_de,
  input  logic [NUM_SRC*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]          sel_req,
  output logic                      vout_hs,
  output logic                      vout_vs,
  output logic                      vout_de,
  output logic [DATA_W-1:0]         vout_data,
  output logic [SEL_W-1:0]          cur_sel,
  output logic                      busy,
  output logic                      switch_done,
  output logic                      timeout,
  output logic                      sel_err,
  output logic [15:0]               frame_cnt
);

  localparam int                    TMR_W     = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [TMR_W-1:0]      TMR_LAST  = TMR_W'(WAIT_TIMEOUT - 1);
  localparam logic [SEL_W:0]        NUM_SRC_X = (SEL_W + 1)'(NUM_SRC);
  localparam logic [MUTE_CNT_W-1:0] MUTE_LOAD = MUTE_CNT_W'(MUTE_FRAMES);

  sw_state_t              state, state_nx;
  logic [SEL_W-1:0]       tgt, tgt_nx, cur_sel_nx;
  logic [TMR_W-1:0]       timer, timer_nx;
  logic [MUTE_CNT_W-1:0]  mute_cnt, mute_nx;
  logic                   switch_nx, timeout_nx;
  logic                   sel_valid, sel_inv_p0;

  logic [NUM_SRC-1:0]     src_lead;
  logic                   out_lead;
  logic                   cur_lead, tgt_lead;
  logic                   sel_hs, sel_vs, sel_de;
  logic [DATA_W-1:0]      sel_data;

  vs_edge_det #(
    .WIDTH  (NUM_SRC),
    .VS_POL (VS_POL)
  ) u_src_edge (
    .clk  (clk),
    .rst  (rst),
    .vs   (in_vs),
    .lead (src_lead)
  );

  // Same detector on the registered output stream drives the frame counter
  vs_edge_det #(
    .WIDTH  (1),
    .VS_POL (VS_POL)
  ) u_out_edge (
    .clk  (clk),
    .rst  (rst),
    .vs   (vout_vs),
    .lead (out_lead)
  );

  assign sel_valid = {1'b0, sel_req} < NUM_SRC_X;
  assign busy      = (state != ST_RUN);

  always_comb begin
    sel_hs   = sync_idle(HS_POL);
    sel_vs   = sync_idle(VS_POL);
    sel_de   = 1'b0;
    sel_data = '0;
    cur_lead = 1'b0;
    tgt_lead = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (cur_sel == SEL_W'(i)) begin
        sel_hs   = in_hs[i];
        sel_vs   = in_vs[i];
        sel_de   = in_de[i];
        sel_data = in_data[`VID_SLICE(i, DATA_W)];
        cur_lead = src_lead[i];
      end
      if (tgt == SEL_W'(i)) begin
        tgt_lead = src_lead[i];
      end
    end
  end

  always_comb begin
    state_nx   = state;
    tgt_nx     = tgt;
    timer_nx   = timer;
    mute_nx    = mute_cnt;
    cur_sel_nx = cur_sel;
    switch_nx  = 1'b0;
    timeout_nx = 1'b0;
    case (state)
      ST_RUN: begin
        if (sel_valid && (sel_req != cur_sel)) begin
          tgt_nx   = sel_req;
          timer_nx = '0;
          state_nx = ST_WAIT_VS;
        end
      end
      ST_WAIT_VS: begin
        if (sel_req == cur_sel) begin
          state_nx = ST_RUN;
        end else if (sel_valid && (sel_req != tgt)) begin
          tgt_nx   = sel_req;
          timer_nx = '0;
        end else if (tgt_lead || (timer == TMR_LAST)) begin
          // A real VS edge takes precedence; the watchdog only fires without one
          cur_sel_nx = tgt;
          switch_nx  = 1'b1;
          timeout_nx = ~tgt_lead;
          mute_nx    = MUTE_LOAD;
          state_nx   = (MUTE_FRAMES == 0) ? ST_RUN : ST_MUTE;
        end else begin
          timer_nx = timer + TMR_W'(1);
        end
      end
      ST_MUTE: begin
        if (cur_lead) begin
          if (mute_cnt <= MUTE_CNT_W'(1)) begin
            mute_nx  = '0;
            state_nx = ST_RUN;
          end else begin
            mute_nx = mute_cnt - MUTE_CNT_W'(1);
          end
        end
      end
      default: begin
        state_nx = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      cur_sel     <= SEL_W'(DEFAULT_SEL);
      tgt         <= SEL_W'(DEFAULT_SEL);
      timer       <= '0;
      mute_cnt    <= '0;
      switch_done <= 1'b0;
      timeout     <= 1'b0;
      sel_inv_p0  <= 1'b0;
      sel_err     <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      state       <= state_nx;
      cur_sel     <= cur_sel_nx;
      tgt         <= tgt_nx;
      timer       <= timer_nx;
      mute_cnt    <= mute_nx;
      switch_done <= switch_nx;
      timeout     <= timeout_nx;
      sel_inv_p0  <= ~sel_valid;
      sel_err     <= ~sel_valid & ~sel_inv_p0;
      if (out_lead) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  // Output stage: one register from the selected source to the encoder
  always_ff @(posedge clk) begin
    if (rst) begin
      vout_hs   <= sync_idle(HS_POL);
      vout_vs   <= sync_idle(VS_POL);
      vout_de   <= 1'b0;
      vout_data <= '0;
    end else begin
      vout_hs   <= sel_hs;
      vout_vs   <= sel_vs;
      vout_de   <= sel_de;
      vout_data <= (state == ST_MUTE) ? MUTE_COLOR : sel_data;
    end
  end

endmodule

// File: tb/tb_video_src_switch.sv
// Self-checking bench for video_src_switch: phase-shifted synthetic sources,
// a behavioural switch model, and directed plus randomized select traffic.
module tb_video_src_switch;

  localparam int NS = 4;
  localparam int DW = 24;
  localparam int SW = 4;
  localparam int MF = 1;
  localparam int WT = 1000;
  localparam int HT = 20;
  localparam int VT = 12;
  localparam int FR = HT * VT;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NS-1:0]     in_hs = '0;
  logic [NS-1:0]     in_vs = '0;
  logic [NS-1:0]     in_de = '0;
  logic [NS*DW-1:0]  in_data = '0;
  logic [SW-1:0]     sel_req = '0;
  logic              vout_hs, vout_vs, vout_de;
  logic [DW-1:0]     vout_data;
  logic [SW-1:0]     cur_sel;
  logic              busy, switch_done, timeout, sel_err;
  logic [15:0]       frame_cnt;

  int nchk = 0;
  int nerr = 0;

  video_src_switch #(
    .NUM_SRC      (NS),
    .DATA_W       (DW),
    .SEL_W        (SW),
    .DEFAULT_SEL  (0),
    .HS_POL       (1'b1),
    .VS_POL       (1'b1),
    .MUTE_FRAMES  (MF),
    .MUTE_COLOR   (24'h0),
    .WAIT_TIMEOUT (WT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_hs       (in_hs),
    .in_vs       (in_vs),
    .in_de       (in_de),
    .in_data     (in_data),
    .sel_req     (sel_req),
    .vout_hs     (vout_hs),
    .vout_vs     (vout_vs),
    .vout_de     (vout_de),
    .vout_data   (vout_data),
    .cur_sel     (cur_sel),
    .busy        (busy),
    .switch_done (switch_done),
    .timeout     (timeout),
    .sel_err     (sel_err),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      if (nerr <= 40) $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Sources: frame of VT lines x HT pixels, vsync = lines 0-1, hsync = cols 0-1
  int         phase[NS] = '{0, 70, 140, 200};
  logic [7:0] seed[NS];
  logic [NS-1:0] vs_kill = '0;
  int         cyc = 0;

  initial begin : gen
    for (int i = 0; i < NS; i++) seed[i] = 8'($urandom);
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      for (int i = 0; i < NS; i++) begin
        int pos, ln, col;
        pos = (cyc + phase[i]) % FR;
        ln  = pos / HT;
        col = pos % HT;
        in_hs[i] = (col < 2);
        in_vs[i] = (ln < 2) && !vs_kill[i];
        in_de[i] = (ln >= 3) && (col >= 4) && (col < HT - 2);
        in_data[i*DW +: DW] = {4'(i), 4'(ln), 8'(col), seed[i]};
      end
    end
  end

  // Behavioural model: current source, pending target (-1 none), wait time, mute frames left
  int          m_cur, m_pend, m_wait, m_mute;
  bit [NS-1:0] m_prev_vs;
  bit          m_prev_inv;
  logic        e_hs, e_vs, e_de, e_sw, e_to, e_err, e_vs_prev;
  logic [DW-1:0] e_data;
  int          e_fc;
  int          sw_seen, to_seen, err_seen, zero_de_seen;

  task automatic model_step();
    int s;
    bit inv;
    bit [NS-1:0] edg;
    s = int'(sel_req);
    if (rst) begin
      m_cur = 0; m_pend = -1; m_wait = 0; m_mute = 0;
      m_prev_vs = '0; m_prev_inv = 1'b0;
      e_hs = 0; e_vs = 0; e_de = 0; e_data = '0;
      e_sw = 0; e_to = 0; e_err = 0; e_fc = 0; e_vs_prev = 0;
      return;
    end
    if (e_vs && !e_vs_prev) e_fc = (e_fc + 1) % 65536;
    e_vs_prev = e_vs;
    for (int i = 0; i < NS; i++) edg[i] = in_vs[i] && !m_prev_vs[i];
    inv = (s >= NS);
    e_err = inv && !m_prev_inv;
    m_prev_inv = inv;
    e_hs = in_hs[m_cur];
    e_vs = in_vs[m_cur];
    e_de = in_de[m_cur];
    e_data = (m_mute > 0) ? 24'h0 : in_data[m_cur*DW +: DW];
    e_sw = 0;
    e_to = 0;
    if (m_mute > 0) begin
      if (edg[m_cur]) m_mute--;
    end else if (m_pend < 0) begin
      if (!inv && s != m_cur) begin m_pend = s; m_wait = 0; end
    end else if (s == m_cur) begin
      m_pend = -1;
    end else if (!inv && s != m_pend) begin
      m_pend = s; m_wait = 0;
    end else if (edg[m_pend] || m_wait == WT - 1) begin
      e_sw = 1; e_to = !edg[m_pend];
      m_cur = m_pend; m_pend = -1; m_mute = MF;
    end else begin
      m_wait++;
    end
    m_prev_vs = in_vs;
  endtask

  initial begin : compare
    forever begin
      @(posedge clk);
      model_step();
      #1;
      chk("vout_hs", vout_hs, e_hs);
      chk("vout_vs", vout_vs, e_vs);
      chk("vout_de", vout_de, e_de);
      chk("vout_data", vout_data, e_data);
      chk("cur_sel", cur_sel, m_cur);
      chk("busy", busy, (m_pend >= 0 || m_mute > 0));
      chk("switch_done", switch_done, e_sw);
      chk("timeout", timeout, e_to);
      chk("sel_err", sel_err, e_err);
      chk("frame_cnt", frame_cnt, e_fc);
      if (switch_done === 1'b1) sw_seen++;
      if (timeout === 1'b1) to_seen++;
      if (sel_err === 1'b1) err_seen++;
      if (vout_de === 1'b1 && vout_data === '0) zero_de_seen++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic wait_idle(input string nm, input int bound);
    int n;
    n = 0;
    tick(1);
    while (busy !== 1'b0 && n < bound) begin
      tick(1);
      n++;
    end
    chk(nm, busy, 0);
  endtask

  initial begin : stim
    int n;
    rst = 1'b1;
    sel_req = 0;
    tick(3);
    chk("rst_cur_sel", cur_sel, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_vout_vs", vout_vs, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick(300);
    chk("t1_cur_sel", cur_sel, 0);
    chk("t1_busy", busy, 0);

    // Switch 0 -> 1 mid-frame, one muted frame of src1
    tick(37);
    sw_seen = 0;
    zero_de_seen = 0;
    sel_req = 1;
    wait_idle("t2_idle", 2000);
    chk("t2_switch_once", sw_seen, 1);
    chk("t2_cur_sel", cur_sel, 1);
    chk("t2_muted_pixels", zero_de_seen, 126);

    // Last request wins: 3 then 2 while waiting
    vs_kill[3] = 1'b1;
    sw_seen = 0;
    to_seen = 0;
    sel_req = 3;
    tick(10);
    sel_req = 2;
    wait_idle("t3_idle", 2000);
    chk("t3_switch_once", sw_seen, 1);
    chk("t3_cur_sel", cur_sel, 2);
    chk("t3_no_timeout", to_seen, 0);

    // Cancel by returning to the current source
    sw_seen = 0;
    sel_req = 3;
    tick(10);
    chk("t3_waiting", busy, 1);
    sel_req = 2;
    tick(20);
    chk("t3_cancel_no_switch", sw_seen, 0);
    chk("t3_cancel_cur_sel", cur_sel, 2);
    chk("t3_cancel_idle", busy, 0);

    // Watchdog: src3 never produces VS
    to_seen = 0;
    sel_req = 3;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (timeout !== 1'b1 && n < 1200);
    chk("t4_timeout_cycle", n, 1001);
    chk("t4_switch_with_timeout", switch_done, 1);
    #2;
    vs_kill[3] = 1'b0;
    wait_idle("t4_idle", 2000);
    chk("t4_cur_sel", cur_sel, 3);
    chk("t4_timeout_once", to_seen, 1);

    // Invalid requests
    sw_seen = 0;
    err_seen = 0;
    sel_req = 5;
    tick(20);
    chk("t5_sel_err_once", err_seen, 1);
    chk("t5_cur_sel", cur_sel, 3);
    chk("t5_no_switch", sw_seen, 0);
    sel_req = 3;
    tick(3);
    sel_req = 7;
    tick(5);
    chk("t5_sel_err_reentry", err_seen, 2);

    // Reset while muted
    sel_req = 0;
    n = 0;
    while (sw_seen == 0 && n < 1000) begin
      tick(1);
      n++;
    end
    chk("t5_switch_seen", sw_seen, 1);
    tick(5);
    chk("t5_in_mute", busy, 1);
    rst = 1'b1;
    tick(1);
    chk("t5_rst_cur_sel", cur_sel, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_frame_cnt", frame_cnt, 0);
    chk("t5_rst_vout_data", vout_data, 0);
    rst = 1'b0;

    // Randomized select traffic, including invalid codes
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 149) == 0) sel_req = SW'($urandom_range(0, 5));
      tick(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
